// File: rtl/shift_issue_stage.sv
// Issue stage ahead of the ALU shift unit: decodes RV32I shift ops and presents
// them through a two-entry output/skid buffer so backpressure never costs throughput.
module shift_issue_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic                  in_is_imm,
  input  logic [DATA_WIDTH-1:0] in_rs1,
  input  logic [DATA_WIDTH-1:0] in_rs2,
  input  logic [4:0]            in_imm_shamt,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [4:0]            out_shift_amount,
  output logic                  out_arith,
  output logic                  out_direction,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  illegal_pulse,
  output logic [15:0]           illegal_count
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [4:0]            amt;
    logic                  arith;
    logic                  dir;
    logic [TAG_WIDTH-1:0]  tag;
  } op_t;

  // Returns {legal, arith, direction}.
  function automatic logic [2:0] decode(input logic [2:0] f3, input logic [6:0] f7);
    logic [2:0] d;
    d = 3'b000;
    if (f3 == 3'b001 && f7 == 7'b0000000)      d = 3'b101;
    else if (f3 == 3'b101 && f7 == 7'b0000000) d = 3'b100;
    else if (f3 == 3'b101 && f7 == 7'b0100000) d = 3'b110;
    return d;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [2:0] dec;
  op_t        in_op;
  op_t        or_q;
  op_t        sr_q;
  logic       or_valid;
  logic       sr_valid;
  logic       in_ready_q;
  logic       accept;
  logic       push;
  logic       or_free;
  logic       rs2_unused;

  always_comb begin
    dec          = decode(in_funct3, in_funct7);
    in_op.a      = in_rs1;
    in_op.amt    = in_is_imm ? in_imm_shamt : in_rs2[4:0];
    in_op.arith  = dec[1];
    in_op.dir    = dec[0];
    in_op.tag    = in_tag;
  end

  assign rs2_unused = ^in_rs2[DATA_WIDTH-1:5];

  assign accept  = in_valid && in_ready_q && !flush;
  assign push    = accept && dec[2];
  assign or_free = !or_valid || out_ready;

  // Stage boundary: input -> output register, overflow parked in the skid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid      <= 1'b0;
      sr_valid      <= 1'b0;
      in_ready_q    <= 1'b1;
      or_q          <= '0;
      sr_q          <= '0;
      illegal_pulse <= 1'b0;
      illegal_count <= 16'd0;
    end else if (flush) begin
      or_valid      <= 1'b0;
      sr_valid      <= 1'b0;
      in_ready_q    <= 1'b1;
      illegal_pulse <= 1'b0;
    end else begin
      illegal_pulse <= accept && !dec[2];
      if (accept && !dec[2]) illegal_count <= sat_inc(illegal_count);
      if (or_free) begin
        if (sr_valid) begin
          or_q       <= sr_q;
          or_valid   <= 1'b1;
          if (push) sr_q <= in_op;
          sr_valid   <= push;
          in_ready_q <= !push;
        end else begin
          if (push) or_q <= in_op;
          or_valid   <= push;
          in_ready_q <= 1'b1;
        end
      end else if (push) begin
        sr_q       <= in_op;
        sr_valid   <= 1'b1;
        in_ready_q <= 1'b0;
      end
    end
  end

  assign in_ready         = in_ready_q;
  assign out_valid        = or_valid;
  assign out_a            = or_q.a;
  assign out_shift_amount = or_q.amt;
  assign out_arith        = or_q.arith;
  assign out_direction    = or_q.dir;
  assign out_tag          = or_q.tag;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Bench for shift_issue_stage: directed scenarios plus random traffic against a
// queue-based model of a two-deep in-order buffer.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic        in_is_imm = 1'b0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [4:0]  in_imm_shamt = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a;
  logic [4:0]  out_shift_amount;
  logic        out_arith;
  logic        out_direction;
  logic [4:0]  out_tag;
  logic        illegal_pulse;
  logic [15:0] illegal_count;

  int n_checks = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [4:0]  amt;
    logic        arith;
    logic        dir;
    logic [4:0]  tag;
  } op_t;

  op_t         mq[$];
  logic        m_pulse = 1'b0;
  logic [15:0] m_count = 16'd0;

  shift_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_is_imm(in_is_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm_shamt(in_imm_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_shift_amount(out_shift_amount),
    .out_arith(out_arith), .out_direction(out_direction), .out_tag(out_tag),
    .illegal_pulse(illegal_pulse), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  function automatic bit is_legal(input logic [2:0] f3, input logic [6:0] f7);
    return (f3 == 3'd1 && f7 == 7'd0) || (f3 == 3'd5 && (f7 == 7'd0 || f7 == 7'h20));
  endfunction

  // Model of one clock: buffer holds at most two ops, head is presented.
  task automatic tick();
    bit acc, lgl;
    op_t op;
    acc = in_valid && (mq.size() < 2) && !flush;
    lgl = is_legal(in_funct3, in_funct7);
    op.a     = in_rs1;
    op.amt   = in_is_imm ? in_imm_shamt : in_rs2[4:0];
    op.arith = (in_funct7 == 7'h20);
    op.dir   = (in_funct3 == 3'd1);
    op.tag   = in_tag;
    if (flush) begin
      mq.delete();
      m_pulse = 1'b0;
    end else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (acc && lgl) mq.push_back(op);
      m_pulse = acc && !lgl;
      if (acc && !lgl && m_count != 16'hFFFF) m_count = m_count + 16'd1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [4:0] sh, input logic [4:0] tag);
    in_valid = 1'b1; in_funct3 = f3; in_funct7 = f7; in_is_imm = imm;
    in_rs1 = rs1; in_rs2 = rs2; in_imm_shamt = sh; in_tag = tag;
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_pulse !== 1'b0 || illegal_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_ctrl: got valid=%b ready=%b pulse=%b count=%h, want 0 1 0 0000",
               out_valid, in_ready, illegal_pulse, illegal_count);
    end
    n_checks++;
    if (out_a !== 32'd0 || out_shift_amount !== 5'd0 || out_arith !== 1'b0 ||
        out_direction !== 1'b0 || out_tag !== 5'd0) begin
      n_err++;
      $display("FAIL reset_data: got a=%h amt=%0d ar=%b dir=%b tag=%0d, want all 0",
               out_a, out_shift_amount, out_arith, out_direction, out_tag);
    end
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    drive(3'b101, 7'b0100000, 1'b0, 32'h8000_00F0, 32'h0000_0024, 5'd0, 5'd3);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_shift_amount !== 5'd4 || out_arith !== 1'b1 ||
        out_direction !== 1'b0 || out_a !== 32'h8000_00F0 || out_tag !== 5'd3) begin
      n_err++;
      $display("FAIL decode_sra: got v=%b amt=%0d ar=%b dir=%b a=%h tag=%0d, want 1 4 1 0 800000f0 3",
               out_valid, out_shift_amount, out_arith, out_direction, out_a, out_tag);
    end
    drive(3'b001, 7'b0000000, 1'b1, 32'h8000_00F0, 32'h0000_0024, 5'd31, 5'd4);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_shift_amount !== 5'd31 || out_arith !== 1'b0 ||
        out_direction !== 1'b1 || out_tag !== 5'd4) begin
      n_err++;
      $display("FAIL decode_slli: got v=%b amt=%0d ar=%b dir=%b tag=%0d, want 1 31 0 1 4",
               out_valid, out_shift_amount, out_arith, out_direction, out_tag);
    end
    drive(3'b101, 7'b0000000, 1'b0, 32'h1234_5678, 32'hFFFF_FFE7, 5'd2, 5'd5);
    tick();
    n_checks++;
    if (out_shift_amount !== 5'd7 || out_arith !== 1'b0 || out_direction !== 1'b0) begin
      n_err++;
      $display("FAIL decode_srl: got amt=%0d ar=%b dir=%b, want 7 0 0",
               out_shift_amount, out_arith, out_direction);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready);
      end
      drive(3'b001, 7'd0, 1'b1, $urandom, $urandom, 5'(i), 5'(i));
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_tag !== 5'(i)) begin
        n_err++;
        $display("FAIL stream_out[%0d]: got v=%b tag=%0d want v=1 tag=%0d", i, out_valid, out_tag, i);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_end: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] got[$];
    bit acc;
    out_ready = 1'b0;
    drive(3'b101, 7'h20, 1'b0, 32'hA, 32'h1, 5'd0, 5'd0);
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_first: got ready=%b valid=%b want 1 1", in_ready, out_valid);
    end
    drive(3'b101, 7'h20, 1'b0, 32'hB, 32'h2, 5'd0, 5'd1);
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd0) begin
      n_err++;
      $display("FAIL bp_full: got ready=%b valid=%b tag=%0d want 0 1 0", in_ready, out_valid, out_tag);
    end
    drive(3'b101, 7'h20, 1'b0, 32'hC, 32'h3, 5'd0, 5'd2);
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_tag !== 5'd0) begin
      n_err++;
      $display("FAIL bp_hold: got ready=%b tag=%0d want 0 0", in_ready, out_tag);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid === 1'b1) got.push_back(out_tag);
      acc = in_valid && (mq.size() < 2);
      tick();
      if (acc) in_valid = 1'b0;
    end
    n_checks++;
    if (got.size() != 3) begin
      n_err++;
      $display("FAIL bp_count: got %0d ops want 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (got[k] !== 5'(k)) begin
          n_err++;
          $display("FAIL bp_order[%0d]: got tag %0d want %0d", k, got[k], k);
        end
      end
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(3'b101, 7'b0000001, 1'b0, 32'h5, 32'h5, 5'd0, 5'd9);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || illegal_pulse !== 1'b1 || illegal_count !== 16'd1) begin
      n_err++;
      $display("FAIL illegal_one: got v=%b pulse=%b count=%h want 0 1 0001",
               out_valid, illegal_pulse, illegal_count);
    end
    tick();
    n_checks++;
    if (illegal_pulse !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_pulse_width: got pulse=%b v=%b want 0 0", illegal_pulse, out_valid);
    end
    drive(3'b001, 7'h20, 1'b0, 32'h5, 32'h5, 5'd0, 5'd9);
    for (int i = 0; i < 65533; i++) tick();
    n_checks++;
    if (illegal_count !== 16'hFFFE) begin
      n_err++;
      $display("FAIL illegal_preload: got %h want fffe", illegal_count);
    end
    tick();
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (illegal_count !== 16'hFFFF || illegal_pulse !== 1'b1) begin
      n_err++;
      $display("FAIL illegal_saturate: got count=%h pulse=%b want ffff 1", illegal_count, illegal_pulse);
    end
    tick();
  endtask

  task automatic test_flush();
    logic [15:0] cnt0;
    cnt0 = illegal_count;
    out_ready = 1'b0;
    drive(3'b001, 7'd0, 1'b0, 32'h1, 32'h1, 5'd0, 5'd10);
    tick();
    drive(3'b001, 7'd0, 1'b0, 32'h2, 32'h1, 5'd0, 5'd11);
    tick();
    drive(3'b001, 7'd0, 1'b0, 32'h3, 32'h1, 5'd0, 5'd12);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_count !== cnt0) begin
      n_err++;
      $display("FAIL flush_state: got v=%b ready=%b count=%h want 0 1 %h",
               out_valid, in_ready, illegal_count, cnt0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_leak[%0d]: got valid tag=%0d want nothing", i, out_tag);
      end
      tick();
    end
    drive(3'b111, 7'h7F, 1'b0, 32'h0, 32'h0, 5'd0, 5'd13);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (illegal_pulse !== 1'b0 || illegal_count !== cnt0) begin
      n_err++;
      $display("FAIL flush_illegal: got pulse=%b count=%h want 0 %h", illegal_pulse, illegal_count, cnt0);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(3'b101, 7'd0, 1'b0, 32'h7, 32'h1, 5'd0, 5'd20);
    tick();
    drive(3'b101, 7'd0, 1'b0, 32'h8, 32'h1, 5'd0, 5'd21);
    tick();
    #1;
    rst_n = 1'b0;
    mq.delete();
    m_pulse = 1'b0;
    m_count = 16'd0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_async: got v=%b ready=%b count=%h want 0 1 0000",
               out_valid, in_ready, illegal_count);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0] f3s[8] = '{3'd1, 3'd5, 3'd5, 3'd5, 3'd1, 3'd0, 3'd3, 3'd5};
    logic [6:0] f7s[8] = '{7'd0, 7'd0, 7'h20, 7'd1, 7'h20, 7'd0, 7'd0, 7'h40};
    int sel;
    for (int c = 0; c < 600; c++) begin
      n_checks++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
          illegal_pulse !== m_pulse || illegal_count !== m_count) begin
        n_err++;
        $display("FAIL rand_ctrl@%0d: got v=%b r=%b p=%b c=%h want v=%b r=%b p=%b c=%h", c,
                 out_valid, in_ready, illegal_pulse, illegal_count,
                 mq.size() > 0, mq.size() < 2, m_pulse, m_count);
      end
      if (mq.size() > 0) begin
        n_checks++;
        if ({out_a, out_shift_amount, out_arith, out_direction, out_tag} !== mq[0]) begin
          n_err++;
          $display("FAIL rand_data@%0d: got a=%h amt=%0d ar=%b dir=%b tag=%0d want a=%h amt=%0d ar=%b dir=%b tag=%0d",
                   c, out_a, out_shift_amount, out_arith, out_direction, out_tag,
                   mq[0].a, mq[0].amt, mq[0].arith, mq[0].dir, mq[0].tag);
        end
      end
      sel = (($urandom % 4) == 0) ? int'($urandom % 8) : int'($urandom % 3);
      drive(f3s[sel], f7s[sel], 1'($urandom), $urandom, $urandom, 5'($urandom), 5'($urandom));
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 20) == 0;
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_decode();
    test_streaming();
    test_backpressure();
    test_illegal();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Pipeline stage directly upstream of the ALU shift unit.
- Accepts decoded RV32I shift instructions (SLL/SRL/SRA and immediate forms) over a valid/ready handshake.
- Decodes funct3/funct7 into shift controls and selects the shift amount.
- Presents registered operands and controls to the shift unit through a 2-entry skid buffer, so full throughput holds under downstream backpressure.

Parameters:
- DATA_WIDTH, 32, operand width; only 32 is supported (shift amount fixed at 5 bits).
- TAG_WIDTH, 5, destination-register tag carried alongside the operation.

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline flush
- in_valid  input  1  upstream has an instruction
- in_ready  output  1  stage can accept
- in_funct3  input  3  instruction funct3
- in_funct7  input  7  instruction funct7 (imm[11:5] for immediate forms)
- in_is_imm  input  1  1 = immediate form (SLLI/SRLI/SRAI)
- in_rs1  input  DATA_WIDTH  rs1 value
- in_rs2  input  DATA_WIDTH  rs2 value
- in_imm_shamt  input  5  imm[4:0]
- in_tag  input  TAG_WIDTH  destination tag
- out_valid  output  1  operation presented to shift unit
- out_ready  input  1  downstream accepts
- out_a  output  DATA_WIDTH  operand to shift
- out_shift_amount  output  5  shift amount
- out_arith  output  1  1 = arithmetic right shift
- out_direction  output  1  1 = left, 0 = right
- out_tag  output  TAG_WIDTH  destination tag
- illegal_pulse  output  1  one-cycle pulse, illegal encoding dropped
- illegal_count  output  16  saturating count of illegal encodings

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, illegal_pulse=0, illegal_count=0, skid empty, in_ready=1.
  - All data outputs are 0.
- Handshakes:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - in_valid and out_valid never depend combinationally on the ready of the same interface.
- Decode:
  - funct3=001, funct7=0000000 -> direction=1, arith=0 (SLL).
  - funct3=101, funct7=0000000 -> direction=0, arith=0 (SRL).
  - funct3=101, funct7=0100000 -> direction=0, arith=1 (SRA).
  - Any other funct3/funct7 combination is illegal.
- Shift amount: in_is_imm ? in_imm_shamt : in_rs2[4:0]; upper rs2 bits are ignored. out_a = in_rs1.
- Illegal accept:
  - Transfer completes (in_ready honoured); the entry is not enqueued.
  - illegal_pulse=1 in the next cycle.
  - illegal_count increments and saturates at 16'hFFFF.
- Storage:
  - Output register (OR) plus skid register (SR).
  - in_ready is a registered value equal to !SR_valid.
  - Latency: 1 cycle from input transfer to out_valid.
  - Throughput: 1 op/cycle while out_ready=1.
- Per-cycle transitions:
  - OR empty or OR transfers out: new legal input loads OR (from SR first if SR valid; in that case the input loads SR).
  - OR full and stalled: new legal input loads SR; in_ready drops next cycle.
  - SR drains to OR on the cycle OR transfers out; in_ready rises the following cycle.
  - Order is preserved: SR content always precedes any later input.
- Flush:
  - Synchronous; clears OR_valid and SR_valid; in_ready=1 next cycle.
  - Flush wins over a simultaneous input or output transfer: the input is discarded and no illegal pulse or count is generated for it.
  - illegal_count is not cleared by flush.
- Mid-operation reset clears everything immediately, regardless of clock.

Test Plan:
- Reset: rst_n low mid-stream with OR and SR full -> out_valid=0, in_ready=1, illegal_count=0 asynchronously.
- Decode: rs1=32'h8000_00F0, rs2=32'h0000_0024, in_is_imm=0:
  - SRA (101/0100000) -> shift_amount=4, arith=1, direction=0 after 1 cycle.
  - SLLI with imm_shamt=31 -> shift_amount=31, direction=1, arith=0.
- Streaming: 8 back-to-back legal ops with out_ready=1 -> 8 consecutive out_valid cycles, tags 0..7 in order, in_ready constantly 1.
- Backpressure: out_ready=0 while 3 ops offered -> OR and SR fill, in_ready=0 after the 2nd accept. Then release out_ready -> tags emerge 0,1,2 in order with no loss or duplicate.
- Illegal: funct3=101, funct7=0000001 -> no out_valid, illegal_pulse high exactly 1 cycle, illegal_count=1. Preload count 16'hFFFE plus 2 illegal ops -> count stays at 16'hFFFF.
- Flush: flush asserted with SR full and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, flushed tags never appear, illegal_count unchanged.
